// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared register map, bit indices and seven-segment decode
package io_pkg;

  localparam logic [3:0] OFF_SW_LO  = 4'h0;
  localparam logic [3:0] OFF_SW_HI  = 4'h1;
  localparam logic [3:0] OFF_LED_LO = 4'h2;
  localparam logic [3:0] OFF_LED_HI = 4'h3;
  localparam logic [3:0] OFF_DISP0  = 4'h4;
  localparam logic [3:0] OFF_DISP1  = 4'h5;
  localparam logic [3:0] OFF_DISP2  = 4'h6;
  localparam logic [3:0] OFF_DISP3  = 4'h7;
  localparam logic [3:0] OFF_CTRL   = 4'hC;
  localparam logic [3:0] OFF_EVT    = 4'hD;

  localparam int CTRL_SRC_BIT   = 0;
  localparam int CTRL_BLANK_BIT = 1;
  localparam int EVT_SW_BIT     = 0;

  // Active-low cathode pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit synchronizer and stability-counter debouncer
module switch_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_deb,
  output logic             changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] deb_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] accept;

  // A bit is accepted when it has differed for the full stability window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // Synchronizer chain, stability counters and debounced state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_deb = deb_q;
  // High during the cycle whose closing edge updates sw_deb, so a consumer
  // registering on the same edge sees the event together with the new value.
  assign changed = |accept;

endmodule

// File: rtl/mmio_io_controller.sv
// rtl/mmio_io_controller.sv - memory-mapped switch, LED and seven-segment block
module mmio_io_controller
  import io_pkg::*;
#(
  parameter int               DATA_W          = 8,
  parameter int               D_ADDR_W        = 12,
  parameter int               NUM_SW          = 16,
  parameter int               NUM_LED         = 16,
  parameter int               NUM_DIGITS      = 4,
  parameter logic [D_ADDR_W-1:0] MMIO_BASE    = 12'hFF0,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter int               SCAN_CYCLES     = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SW-1:0]       sw,
  output logic [NUM_LED-1:0]      led,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  input  logic [D_ADDR_W-1:0]     data_addr,
  input  logic                    write_enable,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  output logic                    int_mem_select,
  input  logic [4*NUM_DIGITS-1:0] debug_value
);

  localparam int PRE_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_CYCLES - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [16:0] LED_MASK17  = (17'd1 << NUM_LED) - 17'd1;
  localparam logic [32:0] DISP_MASK33 = (33'd1 << (4 * NUM_DIGITS)) - 33'd1;
  localparam logic [15:0] LED_MASK  = LED_MASK17[15:0];
  localparam logic [31:0] DISP_MASK = DISP_MASK33[31:0];

  logic [NUM_SW-1:0] sw_deb;
  logic              sw_changed;
  logic [15:0]       sw_ext;
  logic [15:0]       led_q;
  logic [31:0]       disp_q;
  logic [1:0]        ctrl_q;
  logic              evt_q;
  logic [PRE_W-1:0]  pre_q;
  logic [2:0]        idx_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic [31:0]       disp_src;
  logic              in_window;
  logic [3:0]        offset;
  logic              wr;

  switch_debouncer #(
    .WIDTH           (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw),
    .sw_deb  (sw_deb),
    .changed (sw_changed)
  );

  assign in_window      = (data_addr[D_ADDR_W-1:4] == MMIO_BASE[D_ADDR_W-1:4]);
  assign int_mem_select = ~in_window;
  assign offset         = data_addr[3:0];
  assign wr             = write_enable && in_window;

  // Zero-extend the debounced switches and pick the display nibble source.
  always_comb begin
    sw_ext = '0;
    sw_ext[NUM_SW-1:0] = sw_deb;
    disp_src = '0;
    if (ctrl_q[CTRL_SRC_BIT]) begin
      disp_src = disp_q;
    end else begin
      disp_src[4*NUM_DIGITS-1:0] = debug_value;
    end
  end

  // Register read mux; anything unmapped or outside the window reads 0.
  always_comb begin
    read_data = '0;
    if (in_window) begin
      case (offset)
        OFF_SW_LO:  read_data = sw_ext[7:0];
        OFF_SW_HI:  read_data = sw_ext[15:8];
        OFF_LED_LO: read_data = led_q[7:0];
        OFF_LED_HI: read_data = led_q[15:8];
        OFF_DISP0:  read_data = disp_q[7:0];
        OFF_DISP1:  read_data = disp_q[15:8];
        OFF_DISP2:  read_data = disp_q[23:16];
        OFF_DISP3:  read_data = disp_q[31:24];
        OFF_CTRL:   read_data = {6'b0, ctrl_q};
        OFF_EVT:    read_data = {7'b0, evt_q};
        default:    read_data = '0;
      endcase
    end
  end

  // Writable registers; storage beyond the configured LEDs/digits stays 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_q  <= '0;
      disp_q <= '0;
      ctrl_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      if (wr) begin
        case (offset)
          OFF_LED_LO: led_q[7:0]    <= write_data & LED_MASK[7:0];
          OFF_LED_HI: led_q[15:8]   <= write_data & LED_MASK[15:8];
          OFF_DISP0:  disp_q[7:0]   <= write_data & DISP_MASK[7:0];
          OFF_DISP1:  disp_q[15:8]  <= write_data & DISP_MASK[15:8];
          OFF_DISP2:  disp_q[23:16] <= write_data & DISP_MASK[23:16];
          OFF_DISP3:  disp_q[31:24] <= write_data & DISP_MASK[31:24];
          OFF_CTRL:   ctrl_q        <= write_data[1:0];
          default:    ;
        endcase
      end
      // A new switch event takes priority over a simultaneous clear.
      if (sw_changed) begin
        evt_q <= 1'b1;
      end else if (wr && (offset == OFF_EVT) && write_data[EVT_SW_BIT]) begin
        evt_q <= 1'b0;
      end
    end
  end

  // Digit scan prescaler and index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Registered anode and cathode drive for the current digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
    end else begin
      an_q  <= ctrl_q[CTRL_BLANK_BIT] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_q <= hex_to_seg(disp_src[idx_q*4 +: 4]);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign led = led_q[NUM_LED-1:0];

endmodule
